// File: rtl/proc_pkg.sv
// Shared processor constants and helpers: word/byte geometry and little-endian
// byte-lane extraction used by the memory-side pipeline blocks.
package proc_pkg;

  localparam int WORD_OFF   = 2;   // byte-offset bits inside a word
  localparam int BYTE_W     = 8;   // byte-lane width
  localparam int LANE_MAX_W = 64;  // widest data path byte_lane accepts

  // Little-endian lane select: off = 0 returns bits [7:0].
  function automatic logic [BYTE_W-1:0] byte_lane(input logic [LANE_MAX_W-1:0] word,
                                                  input logic [WORD_OFF-1:0]   off);
    return word[off*BYTE_W +: BYTE_W];
  endfunction

endpackage

// File: rtl/sb_match.sv
// Youngest-match priority search over the store-buffer entries, comparing word
// addresses only. Entries are visited oldest-to-youngest so the last hit wins.
module sb_match
  import proc_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int ADDR_W = 32,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int WADR_W = ADDR_W - WORD_OFF
) (
  input  logic [DEPTH-1:0]             valid,
  input  logic [DEPTH-1:0][WADR_W-1:0] wadr,
  input  logic [PTR_W-1:0]             head,
  input  logic [WADR_W-1:0]            ld_wadr,
  output logic                         hit,
  output logic [PTR_W-1:0]             idx
);

  logic [PTR_W-1:0] slot;

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path through the block leaves it holding a value (which would infer a latch).
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      // DEPTH is a power of two, so truncating the sum wraps modulo DEPTH.
      slot = head + PTR_W'(i);
      if (valid[slot] && wadr[slot] == ld_wadr) begin
        hit = 1'b1;
        idx = slot;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between the M stage and the data cache, with
// load forwarding from the youngest word-address match.
module store_buffer
  import proc_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              st_valid,
  input  logic [ADDR_W-1:0]                 st_addr,
  input  logic [DATA_W-1:0]                 st_data,
  input  logic                              st_byte,
  output logic                              st_stall,
  input  logic                              ld_valid,
  input  logic [ADDR_W-1:0]                 ld_addr,
  input  logic                              ld_byte,
  output logic                              ld_hit,
  output logic [DATA_W-1:0]                 ld_data,
  output logic                              ld_conflict,
  output logic                              cache_wr,
  output logic [ADDR_W-1:0]                 cache_addr,
  output logic [DATA_W-1:0]                 cache_data,
  output logic                              cache_byte,
  input  logic                              cache_ready,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic                              empty
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WADR_W = ADDR_W - WORD_OFF;

  logic [DEPTH-1:0]               valid_q;
  logic [DEPTH-1:0][WADR_W-1:0]   wadr_q;
  logic [DEPTH-1:0][WORD_OFF-1:0] off_q;
  logic [DEPTH-1:0][DATA_W-1:0]   data_q;
  logic [DEPTH-1:0]               byte_q;
  logic [PTR_W-1:0]               head, tail;

  logic enq, deq;

  assign st_stall   = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign cache_wr   = !empty;
  assign cache_addr = {wadr_q[head], off_q[head]};
  assign cache_data = data_q[head];
  assign cache_byte = byte_q[head];

  assign enq = st_valid && !st_stall;
  assign deq = cache_wr && cache_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      if (enq) begin
        valid_q[tail] <= 1'b1;
        tail          <= tail + PTR_W'(1);
      end
      // Enqueue and retire never hit the same slot: that needs empty or full.
      if (deq) begin
        valid_q[head] <= 1'b0;
        head          <= head + PTR_W'(1);
      end
      unique case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the payload storage has no reset; the valid bits alone decide whether
  // a slot means anything, and leaving RAM-like arrays unreset keeps them cheap.
  always_ff @(posedge clk) begin
    if (enq && !reset) begin
      wadr_q[tail] <= st_addr[ADDR_W-1:WORD_OFF];
      off_q[tail]  <= st_addr[WORD_OFF-1:0];
      data_q[tail] <= st_data;
      byte_q[tail] <= st_byte;
    end
  end

  logic             m_hit;
  logic [PTR_W-1:0] m_idx;

  sb_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_match (
    .valid   (valid_q),
    .wadr    (wadr_q),
    .head    (head),
    .ld_wadr (ld_addr[ADDR_W-1:WORD_OFF]),
    .hit     (m_hit),
    .idx     (m_idx)
  );

  logic [DATA_W-1:0]   e_data;
  logic [WORD_OFF-1:0] e_off, l_off;

  assign e_data = data_q[m_idx];
  assign e_off  = off_q[m_idx];
  assign l_off  = ld_addr[WORD_OFF-1:0];

  always_comb begin
    ld_hit      = 1'b0;
    ld_conflict = 1'b0;
    ld_data     = '0;
    if (ld_valid && m_hit) begin
      if (!byte_q[m_idx]) begin
        ld_hit  = 1'b1;
        ld_data = ld_byte ? DATA_W'(byte_lane(LANE_MAX_W'(e_data), l_off)) : e_data;
      end else if (ld_byte && e_off == l_off) begin
        ld_hit  = 1'b1;
        ld_data = DATA_W'(e_data[BYTE_W-1:0]);
      end else begin
        // A byte store cannot supply a full word or a different byte lane.
        ld_conflict = 1'b1;
      end
    end
  end

endmodule
